// File: rtl/gnr_pkg.sv
// Shared helpers for the GNR Boolean-network node: LUT depth, lane slicing
// and the saturation value of the per-lane transition counters.
package gnr_pkg;

    function automatic int lut_depth(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic logic [63:0] cnt_sat_value(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/gnr_flip_counter.sv
// Per-lane saturating transition counter; sat rises on the same edge the
// count reaches all-ones and both then hold until a sync clear or reset.
module gnr_flip_counter
    import gnr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && !sat) begin
            cnt <= cnt_inc;
            sat <= (cnt_inc == CNT_MAX);
        end
    end

endmodule

// File: rtl/gnr_node_lut.sv
// Generic GNR node: runtime truth table over N_IN parents, slow/fast
// trajectory registers per lane and a per-lane s1 transition counter.
module gnr_node_lut
    import gnr_pkg::*;
#(
    parameter int N_IN    = 3,
    parameter int N_LANES = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reset_nos,
    input  logic                     start_s0,
    input  logic                     start_s1,
    input  logic [N_LANES-1:0]       init_state,
    input  logic [N_LANES*N_IN-1:0]  in_s0,
    input  logic [N_LANES*N_IN-1:0]  in_s1,
    input  logic                     cfg_we,
    input  logic [N_IN-1:0]          cfg_addr,
    input  logic                     cfg_data,
    output logic [N_LANES-1:0]       s0,
    output logic [N_LANES-1:0]       s1,
    output logic [N_LANES-1:0]       node_eq,
    output logic [N_LANES*CNT_W-1:0] flip_cnt,
    output logic [N_LANES-1:0]       flip_sat
);

    localparam int DEPTH = lut_depth(N_IN);

    logic [DEPTH-1:0]   lut;
    logic               pass;
    logic [N_LANES-1:0] nxt_s0;
    logic [N_LANES-1:0] nxt_s1;
    logic [N_LANES-1:0] flip_inc;

    // Evaluation reads the current LUT, so a same-cycle write is seen one edge later.
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        localparam int IN_LSB  = lane_lsb(l, N_IN);
        localparam int CNT_LSB = lane_lsb(l, CNT_W);

        assign nxt_s0[l]   = lut[in_s0[IN_LSB +: N_IN]];
        assign nxt_s1[l]   = lut[in_s1[IN_LSB +: N_IN]];
        assign flip_inc[l] = start_s1 && !reset_nos && (nxt_s1[l] != s1[l]);

        gnr_flip_counter #(
            .CNT_W(CNT_W)
        ) u_flip_counter (
            .clk(clk),
            .rst(rst),
            .clr(reset_nos),
            .inc(flip_inc[l]),
            .cnt(flip_cnt[CNT_LSB +: CNT_W]),
            .sat(flip_sat[l])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lut <= '0;
        end else if (cfg_we) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

    // pass alternates on every slow request; s0 only moves on the pass=1 half.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0   <= '0;
            s1   <= '0;
            pass <= 1'b0;
        end else if (reset_nos) begin
            s0   <= init_state;
            s1   <= init_state;
            pass <= 1'b1;
        end else begin
            if (start_s0) begin
                if (pass) begin
                    s0 <= nxt_s0;
                end
                pass <= !pass;
            end
            if (start_s1) begin
                s1 <= nxt_s1;
            end
        end
    end

    assign node_eq = ~(s0 ^ s1);

endmodule

// File: tb/tb_gnr_node_lut.sv
// Scoreboard bench for gnr_node_lut: a behavioural model predicts each cycle's
// outputs into a queue and a monitor compares them against the DUT.
module tb_gnr_node_lut;

    localparam int N_IN    = 3;
    localparam int N_LANES = 4;
    localparam int CNT_W   = 4;
    localparam int DEPTH   = 8;
    localparam int CMAX    = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reset_nos = 1'b0;
    logic        start_s0 = 1'b0;
    logic        start_s1 = 1'b0;
    logic [3:0]  init_state = '0;
    logic [11:0] in_s0 = '0;
    logic [11:0] in_s1 = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic        cfg_data = 1'b0;
    logic [3:0]  s0, s1, node_eq, flip_sat;
    logic [15:0] flip_cnt;

    gnr_node_lut #(.N_IN(N_IN), .N_LANES(N_LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .reset_nos(reset_nos),
        .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
        .in_s0(in_s0), .in_s1(in_s1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .s0(s0), .s1(s1), .node_eq(node_eq),
        .flip_cnt(flip_cnt), .flip_sat(flip_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [3:0]  eq;
        logic [3:0]  sat;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    bit lut_m[DEPTH];
    bit s0m[N_LANES];
    bit s1m[N_LANES];
    int cntm[N_LANES];
    bit pass_m;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) lut_m[i] = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            s0m[l] = 1'b0; s1m[l] = 1'b0; cntm[l] = 0;
        end
        pass_m = 1'b0;
    endtask

    function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [11:0] r12();
        return 12'($urandom);
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input bit rn, input bit st0, input bit st1, input logic [3:0] init,
                        input logic [11:0] i0, input logic [11:0] i1,
                        input bit we, input logic [2:0] wa, input bit wd);
        exp_t e;
        int   idx;
        bit   nv;
        @(negedge clk);
        reset_nos = rn; start_s0 = st0; start_s1 = st1; init_state = init;
        in_s0 = i0; in_s1 = i1; cfg_we = we; cfg_addr = wa; cfg_data = wd;
        if (rn) begin
            for (int l = 0; l < N_LANES; l++) begin
                s0m[l] = init[l]; s1m[l] = init[l]; cntm[l] = 0;
            end
            pass_m = 1'b1;
        end else begin
            if (st0) begin
                if (pass_m) begin
                    for (int l = 0; l < N_LANES; l++) begin
                        idx = int'(i0[l*N_IN +: N_IN]);
                        s0m[l] = lut_m[idx];
                    end
                end
                pass_m = !pass_m;
            end
            if (st1) begin
                for (int l = 0; l < N_LANES; l++) begin
                    idx = int'(i1[l*N_IN +: N_IN]);
                    nv = lut_m[idx];
                    if (nv != s1m[l] && cntm[l] < CMAX) cntm[l]++;
                    s1m[l] = nv;
                end
            end
        end
        if (we) lut_m[wa] = wd;
        for (int l = 0; l < N_LANES; l++) begin
            e.s0[l]  = s0m[l];
            e.s1[l]  = s1m[l];
            e.eq[l]  = (s0m[l] == s1m[l]);
            e.sat[l] = (cntm[l] == CMAX);
            e.cnt[l*4 +: 4] = 4'(cntm[l]);
        end
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 4'h0, r12(), r12(), 0, 3'd0, 0);
    endtask

    task automatic program_lut(input logic [7:0] v);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 4'h0, r12(), r12(), 1, 3'(i), v[i]);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: compares queued expectations shortly after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("s0", 32'(s0), 32'(e.s0));
                cmp("s1", 32'(s1), 32'(e.s1));
                cmp("node_eq", 32'(node_eq), 32'(e.eq));
                cmp("flip_cnt", 32'(flip_cnt), 32'(e.cnt));
                cmp("flip_sat", 32'(flip_sat), 32'(e.sat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] fb;
        model_clear();
        #1 rst = 1'b0;
        #2;
        cmp("rst_s0", 32'(s0), 32'h0);
        cmp("rst_s1", 32'(s1), 32'h0);
        cmp("rst_cnt", 32'(flip_cnt), 32'h0);
        cmp("rst_sat", 32'(flip_sat), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        // AND3 table, fast step
        program_lut(8'h80);
        step(1, 0, 0, 4'b0000, r12(), r12(), 0, 3'd0, 0);
        step(0, 0, 1, 4'h0, r12(), pack4(7, 7, 3, 0), 0, 3'd0, 0);
        settle();
        cmp("and3_s1", 32'(s1), 32'h3);
        cmp("and3_cnt", 32'(flip_cnt), 32'h0011);

        // Slow cadence on lane 0
        step(1, 0, 0, 4'b0000, r12(), r12(), 0, 3'd0, 0);
        step(0, 1, 0, 4'h0, pack4(7, 0, 0, 0), r12(), 0, 3'd0, 0);
        settle(); cmp("slow1", 32'(s0[0]), 32'h1);
        step(0, 1, 0, 4'h0, pack4(7, 0, 0, 0), r12(), 0, 3'd0, 0);
        settle(); cmp("slow2", 32'(s0[0]), 32'h1);
        step(0, 1, 0, 4'h0, pack4(0, 0, 0, 0), r12(), 0, 3'd0, 0);
        settle(); cmp("slow3", 32'(s0[0]), 32'h0);
        step(0, 1, 0, 4'h0, pack4(0, 7, 7, 7), r12(), 0, 3'd0, 0);
        settle(); cmp("slow4", 32'(s0[0]), 32'h0);

        // reset_nos outranks both step requests
        step(1, 1, 1, 4'b1010, 12'hFFF, 12'hFFF, 0, 3'd0, 0);
        settle();
        cmp("prio_s0", 32'(s0), 32'hA);
        cmp("prio_s1", 32'(s1), 32'hA);
        cmp("prio_cnt", 32'(flip_cnt), 32'h0);

        // Read-before-write on entry 7
        step(0, 0, 1, 4'h0, r12(), pack4(7, 7, 7, 7), 1, 3'd7, 0);
        settle(); cmp("rbw_first", 32'(s1), 32'hF);
        step(0, 0, 1, 4'h0, r12(), pack4(7, 7, 7, 7), 0, 3'd0, 0);
        settle(); cmp("rbw_second", 32'(s1), 32'h0);

        // Randomised mix
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 4'($urandom),
                 r12(), r12(), ($urandom_range(0, 9) < 3), 3'($urandom), 1'($urandom));
        end

        // Saturation: NOT of parent 0 with s1 fed back
        program_lut(8'h55);
        step(1, 0, 0, 4'b0000, r12(), r12(), 0, 3'd0, 0);
        for (int k = 1; k <= 20; k++) begin
            fb = r12();
            for (int l = 0; l < N_LANES; l++) fb[l*N_IN] = s1m[l];
            step(0, 0, 1, 4'h0, r12(), fb, 0, 3'd0, 0);
            if (k == 14) begin
                settle();
                cmp("sat14_cnt", 32'(flip_cnt), 32'hEEEE);
                cmp("sat14_flag", 32'(flip_sat), 32'h0);
            end else if (k == 15 || k == 20) begin
                settle();
                cmp("sat_cnt", 32'(flip_cnt), 32'hFFFF);
                cmp("sat_flag", 32'(flip_sat), 32'hF);
            end
        end

        // Asynchronous reset between edges
        program_lut(8'hFF);
        step(1, 0, 0, 4'b0000, r12(), r12(), 0, 3'd0, 0);
        step(0, 1, 1, 4'h0, r12(), r12(), 0, 3'd0, 0);
        @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        cmp("arst_s0", 32'(s0), 32'h0);
        cmp("arst_s1", 32'(s1), 32'h0);
        cmp("arst_cnt", 32'(flip_cnt), 32'h0);
        cmp("arst_sat", 32'(flip_sat), 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0, 4'h0, r12(), r12(), 0, 3'd0, 0);
        step(1, 0, 0, 4'b1111, r12(), r12(), 0, 3'd0, 0);
        step(0, 1, 1, 4'h0, r12(), r12(), 0, 3'd0, 0);
        settle();
        cmp("lut_lost_s0", 32'(s0), 32'h0);
        cmp("lut_lost_s1", 32'(s1), 32'h0);
        idle();
        repeat (3) @(posedge clk);
        #3;
        cmp("queue_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
